// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory AR/R channel pair among several HLS requesters.
// A registered AR slice holds the granted request; an order FIFO steers in-order R bursts back.
module mem_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int AR_W       = 97,
  parameter int R_W        = 519,
  parameter int R_LAST_BIT = 0,
  parameter int MAX_OUT    = 4
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [NUM_REQ*AR_W-1:0]     req_ar_dat,
  input  logic [NUM_REQ-1:0]          req_ar_vld,
  output logic [NUM_REQ-1:0]          req_ar_rdy,
  output logic [R_W-1:0]              req_r_dat,
  output logic [NUM_REQ-1:0]          req_r_vld,
  input  logic [NUM_REQ-1:0]          req_r_rdy,
  output logic [AR_W-1:0]             mem_ar_dat,
  output logic                        mem_ar_vld,
  input  logic                        mem_ar_rdy,
  input  logic [R_W-1:0]              mem_r_dat,
  input  logic                        mem_r_vld,
  output logic                        mem_r_rdy,
  output logic [$clog2(MAX_OUT):0]    outstanding,
  output logic                        orphan_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  typedef enum logic {S_EMPTY, S_FULL} slice_t;

  slice_t             slice_st;
  logic [AR_W-1:0]    slice_dat;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   head;
  logic [IDX_W-1:0]   order_q [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [IDX_W:0]     cand;
  logic [AR_W-1:0]    win_dat;
  logic               found;
  logic               fifo_ne;
  logic               fifo_full;
  logic               pop;
  logic               grant;

  assign fifo_ne   = (count != '0);
  assign fifo_full = (count == CNT_W'(MAX_OUT));
  assign head      = order_q[rd_ptr];
  assign pop       = fifo_ne & mem_r_vld & req_r_rdy[head] & mem_r_dat[R_LAST_BIT];

  // A last-beat pop in the same cycle frees a FIFO slot, so a full FIFO does not block that grant.
  assign grant = (|req_ar_vld)
               & ((slice_st == S_EMPTY) | mem_ar_rdy)
               & (~fifo_full | pop);

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req_ar_vld[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    win_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IDX_W'(k))
        win_dat = req_ar_dat[k*AR_W +: AR_W];
    end
  end

  // Ready is masked by reset so requesters never see a handshake while the block is held in reset.
  always_comb begin
    req_ar_rdy = '0;
    if (grant && arst_n)
      req_ar_rdy[winner] = 1'b1;
    req_r_vld = '0;
    if (fifo_ne)
      req_r_vld[head] = mem_r_vld;
  end

  assign mem_r_rdy   = fifo_ne & req_r_rdy[head];
  assign req_r_dat   = mem_r_dat;
  assign mem_ar_vld  = (slice_st == S_FULL);
  assign mem_ar_dat  = slice_dat;
  assign outstanding = count;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      slice_st   <= S_EMPTY;
      slice_dat  <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (grant) begin
        slice_st  <= S_FULL;
        slice_dat <= win_dat;
        rr_ptr    <= (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        wr_ptr    <= wr_ptr + 1'b1;
      end else if (mem_ar_rdy) begin
        slice_st  <= S_EMPTY;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_r_vld && !fifo_ne)
        orphan_err <= 1'b1;
    end
  end

  // Grant order storage needs no reset: entries are only read behind the occupancy count.
  always_ff @(posedge clk) begin
    if (grant)
      order_q[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed self-checking bench for mem_rd_arbiter: a 2-requester instance for most
// scenarios and a 3-requester instance for round-robin fairness.
module tb_mem_rd_arbiter;

  localparam int AR_W = 97;
  localparam int R_W  = 519;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic [2*AR_W-1:0] ar_dat;
  logic [1:0]        ar_vld, ar_rdy, r_vld, r_rdy;
  logic [R_W-1:0]    r_dat, m_r_dat;
  logic [AR_W-1:0]   m_ar_dat;
  logic              m_ar_vld, m_ar_rdy, m_r_vld, m_r_rdy, orphan;
  logic [2:0]        outst;

  logic [3*AR_W-1:0] ar_dat3;
  logic [2:0]        ar_vld3, ar_rdy3, r_vld3, r_rdy3;
  logic [R_W-1:0]    r_dat3, m_r_dat3;
  logic [AR_W-1:0]   m_ar_dat3;
  logic              m_ar_vld3, m_ar_rdy3, m_r_vld3, m_r_rdy3, orphan3;
  logic [2:0]        outst3;

  mem_rd_arbiter #(.NUM_REQ(2), .AR_W(AR_W), .R_W(R_W), .R_LAST_BIT(0), .MAX_OUT(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_ar_dat(ar_dat), .req_ar_vld(ar_vld), .req_ar_rdy(ar_rdy),
    .req_r_dat(r_dat), .req_r_vld(r_vld), .req_r_rdy(r_rdy),
    .mem_ar_dat(m_ar_dat), .mem_ar_vld(m_ar_vld), .mem_ar_rdy(m_ar_rdy),
    .mem_r_dat(m_r_dat), .mem_r_vld(m_r_vld), .mem_r_rdy(m_r_rdy),
    .outstanding(outst), .orphan_err(orphan)
  );

  mem_rd_arbiter #(.NUM_REQ(3), .AR_W(AR_W), .R_W(R_W), .R_LAST_BIT(0), .MAX_OUT(4)) dut3 (
    .clk(clk), .arst_n(arst_n),
    .req_ar_dat(ar_dat3), .req_ar_vld(ar_vld3), .req_ar_rdy(ar_rdy3),
    .req_r_dat(r_dat3), .req_r_vld(r_vld3), .req_r_rdy(r_rdy3),
    .mem_ar_dat(m_ar_dat3), .mem_ar_vld(m_ar_vld3), .mem_ar_rdy(m_ar_rdy3),
    .mem_r_dat(m_r_dat3), .mem_r_vld(m_r_vld3), .mem_r_rdy(m_r_rdy3),
    .outstanding(outst3), .orphan_err(orphan3)
  );

  function automatic logic [AR_W-1:0] pay(input int k);
    return {1'b1, 32'(k), 64'hCAFE_F00D_0000_0000 + 64'(k)};
  endfunction

  function automatic logic [R_W-1:0] beat(input int k, input logic last);
    logic [R_W-1:0] b;
    b = '0;
    b[R_W-1 -: 32] = 32'(k) ^ 32'h5A5A_0000;
    b[40:9] = 32'(k*7 + 3);
    b[0] = last;
    return b;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire n single-beat bursts on the 2-requester instance.
  task automatic drain(input int n);
    r_rdy = 2'b11;
    for (int i = 0; i < n; i++) begin
      m_r_vld = 1'b1;
      m_r_dat = beat(900 + i, 1'b1);
      step();
    end
    m_r_vld = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    ar_vld = 2'b11; ar_dat = {pay(2), pay(1)};
    m_r_vld = 1'b1; m_r_dat = beat(0, 1'b1); r_rdy = 2'b11; m_ar_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_ar_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_ar_vld got=%0b exp=0", m_ar_vld); end
    checks++; if (ar_rdy !== 2'b00) begin errors++; $display("[TB] FAIL reset_ar_rdy got=%b exp=00", ar_rdy); end
    checks++; if (r_vld !== 2'b00) begin errors++; $display("[TB] FAIL reset_r_vld got=%b exp=00", r_vld); end
    checks++; if (m_r_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_rdy got=%0b exp=0", m_r_rdy); end
    checks++; if (outst !== 3'd0) begin errors++; $display("[TB] FAIL reset_outst got=%0d exp=0", outst); end
    checks++; if (orphan !== 1'b0) begin errors++; $display("[TB] FAIL reset_orphan got=%0b exp=0", orphan); end
    checks++; if (outst3 !== 3'd0) begin errors++; $display("[TB] FAIL reset_outst3 got=%0d exp=0", outst3); end
    ar_vld = 2'b00; m_r_vld = 1'b0;
    #2 arst_n = 1'b1;
    step();
    checks++; if (m_ar_vld !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_ar_vld got=%0b exp=0", m_ar_vld); end
  endtask

  task automatic test_back_to_back();
    m_ar_rdy = 1'b1; r_rdy = 2'b11; m_r_vld = 1'b0;
    ar_vld = 2'b01;
    for (int k = 0; k < 4; k++) begin
      ar_dat[0 +: AR_W] = pay(k);
      #1;
      checks++; if (ar_rdy !== 2'b01) begin errors++; $display("[TB] FAIL b2b_rdy[%0d] got=%b exp=01", k, ar_rdy); end
      step();
      checks++; if (m_ar_vld !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ar_vld[%0d] got=%0b exp=1", k, m_ar_vld); end
      checks++; if (m_ar_dat !== pay(k)) begin errors++; $display("[TB] FAIL b2b_ar_dat[%0d] got=%h exp=%h", k, m_ar_dat, pay(k)); end
      checks++; if (outst !== 3'(k+1)) begin errors++; $display("[TB] FAIL b2b_outst[%0d] got=%0d exp=%0d", k, outst, k+1); end
    end
    ar_dat[0 +: AR_W] = pay(4);
    #1;
    checks++; if (ar_rdy !== 2'b00) begin errors++; $display("[TB] FAIL b2b_full_rdy got=%b exp=00", ar_rdy); end
    step();
    checks++; if (m_ar_vld !== 1'b0) begin errors++; $display("[TB] FAIL b2b_slice_empty got=%0b exp=0", m_ar_vld); end
    checks++; if (outst !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full_outst got=%0d exp=4", outst); end
    checks++; if (ar_rdy !== 2'b00) begin errors++; $display("[TB] FAIL b2b_full_rdy2 got=%b exp=00", ar_rdy); end
    m_r_vld = 1'b1; m_r_dat = beat(1, 1'b1);
    #1;
    checks++; if (ar_rdy !== 2'b01) begin errors++; $display("[TB] FAIL b2b_resume_rdy got=%b exp=01", ar_rdy); end
    checks++; if (r_vld !== 2'b01) begin errors++; $display("[TB] FAIL b2b_resume_r_vld got=%b exp=01", r_vld); end
    checks++; if (m_r_rdy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_resume_r_rdy got=%0b exp=1", m_r_rdy); end
    step();
    ar_vld = 2'b00;
    checks++; if (outst !== 3'd4) begin errors++; $display("[TB] FAIL b2b_swap_outst got=%0d exp=4", outst); end
    checks++; if (m_ar_dat !== pay(4)) begin errors++; $display("[TB] FAIL b2b_resume_dat got=%h exp=%h", m_ar_dat, pay(4)); end
    drain(4);
    checks++; if (outst !== 3'd0) begin errors++; $display("[TB] FAIL b2b_drain_outst got=%0d exp=0", outst); end
    checks++; if (orphan !== 1'b0) begin errors++; $display("[TB] FAIL b2b_orphan got=%0b exp=0", orphan); end
  endtask

  task automatic test_fairness();
    int cnt[3] = '{0, 0, 0};
    int exp;
    m_ar_rdy3 = 1'b1; r_rdy3 = 3'b111; m_r_dat3 = beat(5, 1'b1); m_r_vld3 = 1'b0;
    ar_dat3 = {pay(32), pay(31), pay(30)};
    ar_vld3 = 3'b111;
    for (int g = 0; g < 6; g++) begin
      exp = g % 3;
      #1;
      checks++; if (ar_rdy3 !== 3'(1 << exp)) begin errors++; $display("[TB] FAIL fair_order[%0d] got=%b exp=%b", g, ar_rdy3, 3'(1 << exp)); end
      for (int i = 0; i < 3; i++) if (ar_rdy3[i]) cnt[i]++;
      step();
      checks++; if (m_ar_dat3 !== pay(30 + exp)) begin errors++; $display("[TB] FAIL fair_dat[%0d] got=%h exp=%h", g, m_ar_dat3, pay(30 + exp)); end
      m_r_vld3 = 1'b1;
    end
    ar_vld3 = 3'b000;
    step();
    m_r_vld3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cnt[i] !== 2) begin errors++; $display("[TB] FAIL fair_count[%0d] got=%0d exp=2", i, cnt[i]); end
    end
    checks++; if (outst3 !== 3'd0) begin errors++; $display("[TB] FAIL fair_outst got=%0d exp=0", outst3); end
    checks++; if (orphan3 !== 1'b0) begin errors++; $display("[TB] FAIL fair_orphan got=%0b exp=0", orphan3); end
  endtask

  task automatic test_in_order();
    m_ar_rdy = 1'b1; r_rdy = 2'b11; m_r_vld = 1'b0;
    ar_dat[AR_W +: AR_W] = pay(10); ar_vld = 2'b10;
    #1;
    checks++; if (ar_rdy !== 2'b10) begin errors++; $display("[TB] FAIL order_grant1 got=%b exp=10", ar_rdy); end
    step();
    ar_dat[0 +: AR_W] = pay(11); ar_vld = 2'b01;
    #1;
    checks++; if (ar_rdy !== 2'b01) begin errors++; $display("[TB] FAIL order_grant0 got=%b exp=01", ar_rdy); end
    step();
    ar_vld = 2'b00;
    checks++; if (m_ar_dat !== pay(11)) begin errors++; $display("[TB] FAIL order_ar_dat got=%h exp=%h", m_ar_dat, pay(11)); end
    checks++; if (outst !== 3'd2) begin errors++; $display("[TB] FAIL order_outst2 got=%0d exp=2", outst); end
    for (int b = 0; b < 4; b++) begin
      m_r_vld = 1'b1; m_r_dat = beat(100 + b, b == 3);
      #1;
      checks++; if (r_vld !== 2'b10) begin errors++; $display("[TB] FAIL order_r_vld1[%0d] got=%b exp=10", b, r_vld); end
      checks++; if (r_dat !== beat(100 + b, b == 3)) begin errors++; $display("[TB] FAIL order_r_dat[%0d] got=%h exp=%h", b, r_dat, beat(100 + b, b == 3)); end
      step();
    end
    checks++; if (outst !== 3'd1) begin errors++; $display("[TB] FAIL order_outst1 got=%0d exp=1", outst); end
    for (int b = 0; b < 2; b++) begin
      m_r_dat = beat(200 + b, b == 1);
      #1;
      checks++; if (r_vld !== 2'b01) begin errors++; $display("[TB] FAIL order_r_vld0[%0d] got=%b exp=01", b, r_vld); end
      checks++; if (m_r_rdy !== 1'b1) begin errors++; $display("[TB] FAIL order_r_rdy[%0d] got=%0b exp=1", b, m_r_rdy); end
      step();
    end
    m_r_vld = 1'b0;
    checks++; if (outst !== 3'd0) begin errors++; $display("[TB] FAIL order_outst0 got=%0d exp=0", outst); end
  endtask

  task automatic test_backpressure();
    m_ar_rdy = 1'b0; r_rdy = 2'b11; m_r_vld = 1'b0;
    ar_vld = 2'b01; ar_dat[0 +: AR_W] = pay(20);
    #1;
    checks++; if (ar_rdy !== 2'b01) begin errors++; $display("[TB] FAIL bp_ar_grant got=%b exp=01", ar_rdy); end
    step();
    ar_dat[0 +: AR_W] = pay(21);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ar_rdy !== 2'b00) begin errors++; $display("[TB] FAIL bp_ar_rdy[%0d] got=%b exp=00", c, ar_rdy); end
      checks++; if (m_ar_dat !== pay(20) || m_ar_vld !== 1'b1) begin errors++; $display("[TB] FAIL bp_ar_hold[%0d] got=%h/%0b exp=%h/1", c, m_ar_dat, m_ar_vld, pay(20)); end
      step();
    end
    m_ar_rdy = 1'b1;
    #1;
    checks++; if (ar_rdy !== 2'b01) begin errors++; $display("[TB] FAIL bp_ar_release got=%b exp=01", ar_rdy); end
    step();
    ar_vld = 2'b00;
    checks++; if (m_ar_dat !== pay(21)) begin errors++; $display("[TB] FAIL bp_ar_next got=%h exp=%h", m_ar_dat, pay(21)); end
    checks++; if (outst !== 3'd2) begin errors++; $display("[TB] FAIL bp_ar_outst got=%0d exp=2", outst); end
    drain(2);
    ar_vld = 2'b10; ar_dat[AR_W +: AR_W] = pay(22);
    step();
    ar_vld = 2'b00;
    m_r_vld = 1'b1; m_r_dat = beat(300, 1'b0);
    step();
    m_r_dat = beat(301, 1'b0); r_rdy = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (m_r_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_r_rdy[%0d] got=%0b exp=0", c, m_r_rdy); end
      checks++; if (r_vld !== 2'b10) begin errors++; $display("[TB] FAIL bp_r_vld[%0d] got=%b exp=10", c, r_vld); end
      step();
    end
    r_rdy = 2'b11;
    #1;
    checks++; if (m_r_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_r_resume got=%0b exp=1", m_r_rdy); end
    step();
    m_r_dat = beat(302, 1'b0);
    step();
    m_r_dat = beat(303, 1'b1);
    checks++; if (outst !== 3'd1) begin errors++; $display("[TB] FAIL bp_r_outst1 got=%0d exp=1", outst); end
    step();
    m_r_vld = 1'b0;
    checks++; if (outst !== 3'd0) begin errors++; $display("[TB] FAIL bp_r_outst0 got=%0d exp=0", outst); end
  endtask

  task automatic test_orphan();
    r_rdy = 2'b11; m_r_vld = 1'b1; m_r_dat = beat(500, 1'b1);
    #1;
    checks++; if (m_r_rdy !== 1'b0) begin errors++; $display("[TB] FAIL orphan_r_rdy got=%0b exp=0", m_r_rdy); end
    checks++; if (r_vld !== 2'b00) begin errors++; $display("[TB] FAIL orphan_r_vld got=%b exp=00", r_vld); end
    checks++; if (orphan !== 1'b0) begin errors++; $display("[TB] FAIL orphan_early got=%0b exp=0", orphan); end
    step();
    checks++; if (orphan !== 1'b1) begin errors++; $display("[TB] FAIL orphan_set got=%0b exp=1", orphan); end
    m_r_vld = 1'b0;
    step();
    checks++; if (orphan !== 1'b1) begin errors++; $display("[TB] FAIL orphan_sticky got=%0b exp=1", orphan); end
  endtask

  task automatic test_reset_mid_burst();
    m_ar_rdy = 1'b1; r_rdy = 2'b11;
    ar_vld = 2'b10; ar_dat[AR_W +: AR_W] = pay(40);
    step();
    ar_vld = 2'b01; ar_dat[0 +: AR_W] = pay(41);
    m_r_vld = 1'b1; m_r_dat = beat(400, 1'b0);
    step();
    m_ar_rdy = 1'b0;
    ar_dat[0 +: AR_W] = pay(42);
    m_r_dat = beat(401, 1'b0);
    #1;
    checks++; if (r_vld !== 2'b10) begin errors++; $display("[TB] FAIL rmb_pre_r_vld got=%b exp=10", r_vld); end
    checks++; if (outst !== 3'd2 || m_ar_vld !== 1'b1) begin errors++; $display("[TB] FAIL rmb_pre_state got=%0d/%0b exp=2/1", outst, m_ar_vld); end
    arst_n = 1'b0;
    #1;
    checks++; if (m_ar_vld !== 1'b0) begin errors++; $display("[TB] FAIL rmb_ar_vld got=%0b exp=0", m_ar_vld); end
    checks++; if (ar_rdy !== 2'b00) begin errors++; $display("[TB] FAIL rmb_ar_rdy got=%b exp=00", ar_rdy); end
    checks++; if (r_vld !== 2'b00) begin errors++; $display("[TB] FAIL rmb_r_vld got=%b exp=00", r_vld); end
    checks++; if (m_r_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rmb_r_rdy got=%0b exp=0", m_r_rdy); end
    checks++; if (outst !== 3'd0) begin errors++; $display("[TB] FAIL rmb_outst got=%0d exp=0", outst); end
    checks++; if (orphan !== 1'b0) begin errors++; $display("[TB] FAIL rmb_orphan got=%0b exp=0", orphan); end
    m_r_vld = 1'b0; ar_vld = 2'b00;
    step();
    #2 arst_n = 1'b1;
    m_ar_rdy = 1'b1; ar_vld = 2'b01; ar_dat[0 +: AR_W] = pay(43);
    #1;
    checks++; if (ar_rdy !== 2'b01) begin errors++; $display("[TB] FAIL rmb_regrant got=%b exp=01", ar_rdy); end
    step();
    ar_vld = 2'b00;
    checks++; if (m_ar_vld !== 1'b1 || m_ar_dat !== pay(43)) begin errors++; $display("[TB] FAIL rmb_new_ar got=%h/%0b exp=%h/1", m_ar_dat, m_ar_vld, pay(43)); end
    checks++; if (outst !== 3'd1) begin errors++; $display("[TB] FAIL rmb_new_outst got=%0d exp=1", outst); end
    drain(1);
    checks++; if (outst !== 3'd0) begin errors++; $display("[TB] FAIL rmb_drain got=%0d exp=0", outst); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ar_dat = '0; ar_vld = '0; r_rdy = '0; m_ar_rdy = 1'b0; m_r_dat = '0; m_r_vld = 1'b0;
    ar_dat3 = '0; ar_vld3 = '0; r_rdy3 = '0; m_ar_rdy3 = 1'b0; m_r_dat3 = '0; m_r_vld3 = 1'b0;
    test_reset();
    test_back_to_back();
    test_fairness();
    test_in_order();
    test_backpressure();
    test_orphan();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

- Shares one memory read-channel pair between up to four Catapult HLS requesters: the AR request channel (97-bit) and the R response channel (519-bit).
- Sits between the HLS RTL instances and the platform memory port inside the accelerator wrapper.
- Round-robin arbitration on AR, with a registered output slice.
- Records grant order in an order FIFO and routes in-order R bursts back to the requester that issued them.

## Interface
- NUM_REQ, 2 — number of requesters, 2..4.
- AR_W, 97 — AR payload width; opaque to this block.
- R_W, 519 — R payload width; opaque except for the last flag.
- R_LAST_BIT, 0 — bit index in the R payload that marks the final beat of a burst.
- MAX_OUT, 4 — order-FIFO depth (maximum outstanding bursts); power of two, 2..16.
- clk  in  1  — single clock for all logic.
- arst_n  in  1  — asynchronous, active-low reset.
- req_ar_dat  in  NUM_REQ*AR_W  — per-requester AR payloads; requester i occupies slice [i*AR_W +: AR_W].
- req_ar_vld  in  NUM_REQ  — per-requester AR valid.
- req_ar_rdy  out  NUM_REQ  — per-requester AR ready.
- req_r_dat  out  R_W  — R payload, broadcast to all requesters.
- req_r_vld  out  NUM_REQ  — per-requester R valid.
- req_r_rdy  in  NUM_REQ  — per-requester R ready.
- mem_ar_dat  out  AR_W  — AR payload to memory.
- mem_ar_vld  out  1  — AR valid to memory.
- mem_ar_rdy  in  1  — AR ready from memory.
- mem_r_dat  in  R_W  — R payload from memory.
- mem_r_vld  in  1  — R valid from memory.
- mem_r_rdy  out  1  — R ready to memory.
- outstanding  out  $clog2(MAX_OUT)+1  — number of granted bursts not yet completed.
- orphan_err  out  1  — sticky flag: R valid arrived with no outstanding burst.

## Operation
- **Handshake rule:** a transfer occurs when vld and rdy are both high on a rising clk edge. Holders keep vld and dat stable until the transfer.
- **AR output slice:**
  - One register holds the payload; states are EMPTY and FULL.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY when mem_ar_rdy is high and there is no grant in the same cycle.
  - FULL→FULL when mem_ar_rdy is high and a new grant occurs in the same cycle (back-to-back).
  - mem_ar_vld equals FULL.
- **Grant condition:** all three must hold:
  - any req_ar_vld is high;
  - the slice is EMPTY, or the slice is FULL with mem_ar_rdy high;
  - the order FIFO is not full, with a same-cycle pop counting as space.
- **Grant selection and effects:**
  - Winner is the first requester with vld high, searching from rr_ptr upward with wrap.
  - Only the winner sees req_ar_rdy high, and only in the grant cycle. req_ar_rdy may depend combinationally on req_ar_vld.
  - On a grant: load the slice, push the winner's index into the order FIFO, set rr_ptr = winner+1 mod NUM_REQ.
- **R routing:** head = order FIFO head; ne = FIFO not empty.
  - req_r_dat = mem_r_dat, always.
  - req_r_vld[head] = mem_r_vld & ne; all other bits are 0.
  - mem_r_rdy = ne & req_r_rdy[head].
  - The FIFO pops on a transferred beat with mem_r_dat[R_LAST_BIT]=1.
- **Orphan responses:** mem_r_vld with the FIFO empty leaves mem_r_rdy low (the beat stalls) and sets orphan_err. orphan_err clears only on reset.
- **outstanding:** +1 on push, −1 on pop, unchanged on a simultaneous push and pop; it equals the FIFO occupancy.
- **Reset (asynchronous, arst_n low):**
  - Forces slice EMPTY, FIFO empty, rr_ptr=0, orphan_err=0.
  - Outputs: mem_ar_vld=0, req_ar_rdy=0, req_r_vld=0, mem_r_rdy=0, outstanding=0.
  - In-flight bursts are discarded; reset must be applied together with the memory side and the requesters.

## Timing
- AR latency: mem_ar_vld rises 1 cycle after the grant edge.
- AR throughput: 1 grant per cycle while mem_ar_rdy stays high and the FIFO has space.
- R path: combinational, zero added latency; burst throughput is 1 beat per cycle.
- FIFO full (MAX_OUT outstanding): no grants. Granting resumes in the same cycle as a last-beat pop.
- A requester holding vld is granted within NUM_REQ grant opportunities (starvation bound).

## Test plan
- **Back-to-back single requester:** req0 vld held high, mem_ar_rdy=1 -> grants every cycle, mem_ar_dat follows req0's payload with 1-cycle lag, outstanding ramps to 4, then grants stop.
- **Fairness with NUM_REQ=3:** all vld high, memory always ready, each R is 1 beat -> grant order 0,1,2,0,1,2; each requester receives exactly 2 of 6 grants.
- **In-order routing:** grant req1 (4-beat burst), then req0 (2-beat) -> the 4 beats assert req_r_vld=2'b10 and the next 2 assert 2'b01; outstanding goes 2→1→0.
- **Backpressure:** req_r_rdy[1]=0 for 3 cycles during req1's burst -> mem_r_rdy=0, no beat lost; mem_ar_rdy=0 for 5 cycles -> mem_ar_dat held stable.
- **Orphan response:** mem_r_vld=1 with nothing outstanding -> mem_r_rdy=0, orphan_err=1 on the next edge and held.
- **Reset mid-burst:** arst_n low during beat 2 of 4 -> all outputs are at reset values immediately (before the next clk edge); after release, a new grant works.
